// File: rtl/instr_encoder.sv
// instr_encoder: maps a control-signal bundle back to its 6-bit opcode, packs the
// 32-bit instruction word and writes it to the instruction memory. It runs as a
// three-state FSM: IDLE (accept), ENC (lookup and register), WR (write strobe).
// Bundles that do not match any opcode set a sticky err and are never written.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic              is_immediate,
  input  logic              src2_check,
  input  logic [1:0]        br,
  input  logic [3:0]        exe_cmd,
  input  logic              shift_arith,
  input  logic [4:0]        dest,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  input  logic [15:0]       imm,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        wb;
    logic        imm_en;
    logic [1:0]  br;
    logic [3:0]  cmd;
    logic        sa;
    logic        s2c;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [15:0] imm;
  } req_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  req_t              req_q, req_d, req_in;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              enc_legal;
  logic [5:0]        enc_op;
  logic [31:0]       enc_word;
  logic [6:0]        ctl;

  assign req_in = '{mr: mem_read, mw: mem_write, wb: wb_en, imm_en: is_immediate,
                    br: br, cmd: exe_cmd, sa: shift_arith, s2c: src2_check,
                    dest: dest, src1: src1, src2: src2, imm: imm};

  // control tuple used for the opcode-class lookup: {mr,mw,wb,imm,br,s2c}
  assign ctl = {req_q.mr, req_q.mw, req_q.wb, req_q.imm_en, req_q.br, req_q.s2c};

  // opcode lookup and field packing from the latched bundle
  always_comb begin
    enc_legal = 1'b0;
    enc_op    = 6'd0;
    enc_word  = 32'h0;
    case (ctl)
      7'b0010_00_1: begin  // R-type
        enc_legal = 1'b1;
        case (req_q.cmd)
          4'b0000: enc_op = 6'b000001;
          4'b0010: enc_op = 6'b000011;
          4'b0100: enc_op = 6'b000101;
          4'b0101: enc_op = 6'b000110;
          4'b0110: enc_op = 6'b000111;
          4'b0111: enc_op = 6'b001000;
          4'b1000: enc_op = req_q.sa ? 6'b001001 : 6'b001010;
          4'b1001: enc_op = 6'b001011;
          4'b1010: enc_op = 6'b001100;
          default: enc_legal = 1'b0;
        endcase
        enc_word = {enc_op, req_q.dest, req_q.src1, req_q.src2, 11'b0};
      end
      7'b0011_00_0: begin  // ADDI / SUBI
        enc_legal = 1'b1;
        case (req_q.cmd)
          4'b0000: enc_op = 6'b100000;
          4'b0010: enc_op = 6'b100001;
          default: enc_legal = 1'b0;
        endcase
        enc_word = {enc_op, req_q.dest, req_q.src1, req_q.imm};
      end
      7'b1011_00_0: begin  // LD
        enc_legal = (req_q.cmd == 4'b0000);
        enc_op    = 6'b100100;
        enc_word  = {enc_op, req_q.dest, req_q.src1, req_q.imm};
      end
      7'b0101_00_1: begin  // ST
        enc_legal = (req_q.cmd == 4'b0000);
        enc_op    = 6'b100101;
        enc_word  = {enc_op, req_q.src2, req_q.src1, req_q.imm};
      end
      7'b0001_01_0: begin  // BEZ
        enc_legal = (req_q.cmd == 4'b0000);
        enc_op    = 6'b101000;
        enc_word  = {enc_op, 5'b0, req_q.src1, req_q.imm};
      end
      7'b0001_10_1: begin  // BNE
        enc_legal = (req_q.cmd == 4'b0000);
        enc_op    = 6'b101001;
        enc_word  = {enc_op, req_q.src2, req_q.src1, req_q.imm};
      end
      7'b0001_11_0: begin  // JMP
        enc_legal = (req_q.cmd == 4'b0000);
        enc_op    = 6'b101010;
        enc_word  = {enc_op, 10'b0, req_q.imm};
      end
      7'b0000_00_0: begin  // NOP encodes as the all-zero word
        enc_legal = (req_q.cmd == 4'b0000);
        enc_word  = 32'h0;
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // next-state and bookkeeping; clear overrides every transition
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    full_d  = full_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = req_in;
          state_d = ENC;
        end
      end
      ENC: begin
        if (enc_legal) begin
          wdata_d = enc_word;
          state_d = WR;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = IDLE;
        cnt_d   = cnt_q + 1'b1;
        // the last slot stays addressed once full so im_addr never wraps
        if (addr_q == LAST_ADDR) full_d = 1'b1;
        else                     addr_d = addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      wdata_q <= 32'h0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !full_q;
  // a write cycle that coincides with clear is dropped
  assign im_wr_en  = (state_q == WR) && !clear;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign err       = err_q;
  assign full      = full_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors; expected writes go into a scoreboard queue
// and an independent monitor pops and compares on every im_wr_en.
module tb_instr_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, clear, req_valid, req_ready;
  logic          mem_read, mem_write, wb_en, is_immediate, src2_check, shift_arith;
  logic [1:0]    br;
  logic [3:0]    exe_cmd;
  logic [4:0]    dest, src1, src2;
  logic [15:0]   imm;
  logic          im_wr_en, err, full;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .is_immediate(is_immediate),
    .src2_check(src2_check), .br(br), .exe_cmd(exe_cmd), .shift_arith(shift_arith),
    .dest(dest), .src1(src1), .src2(src2), .imm(imm),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata),
    .err(err), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst === 1'b1 && im_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %0d data %h expected no write", im_addr, im_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {30'b0, im_addr}, {30'b0, e.addr});
        chk("wr_data", im_wdata, e.data);
      end
    end
  end

  task automatic drive(input logic mr, mw, wb, ie, input logic [1:0] b, input logic [3:0] c,
                       input logic sa, s2c, input logic [4:0] d, s1, s2, input logic [15:0] im);
    mem_read = mr; mem_write = mw; wb_en = wb; is_immediate = ie; br = b; exe_cmd = c;
    shift_arith = sa; src2_check = s2c; dest = d; src1 = s1; src2 = s2; imm = im;
  endtask

  // issue one bundle from a negedge; returns at the negedge after the FSM is back in IDLE
  task automatic send(input logic mr, mw, wb, ie, input logic [1:0] b, input logic [3:0] c,
                      input logic sa, s2c, input logic [4:0] d, s1, s2, input logic [15:0] im,
                      input logic legal, input logic [AW-1:0] a, input logic [31:0] w);
    int n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got req_ready=%b expected 1", req_ready);
      return;
    end
    if (legal) begin
      e.addr = a;
      e.data = w;
      sb.push_back(e);
    end
    drive(mr, mw, wb, ie, b, c, sa, s2c, d, s1, s2, im);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("enc_no_strobe", {31'b0, im_wr_en}, 32'd0);
    @(negedge clk);
    chk("wr_strobe", {31'b0, im_wr_en}, {31'b0, legal});
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; clear = 1'b0; req_valid = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 5'd0, 5'd0, 5'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wr_en", {31'b0, im_wr_en}, 32'd0);
    chk("rst_addr",  {30'b0, im_addr}, 32'd0);
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    chk("rst_full",  {31'b0, full}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // ADD r3 = r1 + r2
    send(0, 0, 1, 0, 2'b00, 4'b0000, 0, 1, 5'd3, 5'd1, 5'd2, 16'h0, 1, 2'd0, 32'h04611000);
    chk("add_count", {29'b0, count}, 32'd1);
    // LD then ST
    send(1, 0, 1, 1, 2'b00, 4'b0000, 0, 0, 5'd4, 5'd0, 5'd0, 16'h0010, 1, 2'd1, 32'h90800010);
    send(0, 1, 0, 1, 2'b00, 4'b0000, 0, 1, 5'd0, 5'd0, 5'd4, 16'h0014, 1, 2'd2, 32'h94800014);
    // mem_read & mem_write together is illegal
    send(1, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 5'd1, 5'd1, 5'd1, 16'h1234, 0, 2'd0, 32'h0);
    chk("illegal_err",   {31'b0, err}, 32'd1);
    chk("illegal_addr",  {30'b0, im_addr}, 32'd3);
    chk("illegal_count", {29'b0, count}, 32'd3);
    // ADDI fills the last slot
    send(0, 0, 1, 1, 2'b00, 4'b0000, 0, 0, 5'd5, 5'd1, 5'd0, 16'h0007, 1, 2'd3, 32'h80A10007);
    chk("full_set",   {31'b0, full}, 32'd1);
    chk("full_ready", {31'b0, req_ready}, 32'd0);
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_addr",  {30'b0, im_addr}, 32'd3);
    // a request while full is held off without error
    drive(0, 0, 1, 0, 2'b00, 4'b0000, 0, 1, 5'd3, 5'd1, 5'd2, 16'h0);
    req_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_count", {29'b0, count}, 32'd4);
    chk("held_full",  {31'b0, full}, 32'd1);
    req_valid = 1'b0;
    pulse_clear();
    chk("clr_addr",  {30'b0, im_addr}, 32'd0);
    chk("clr_full",  {31'b0, full}, 32'd0);
    chk("clr_err",   {31'b0, err}, 32'd0);
    chk("clr_count", {29'b0, count}, 32'd0);
    chk("clr_ready", {31'b0, req_ready}, 32'd1);

    // SLA vs SLL, then BEZ
    send(0, 0, 1, 0, 2'b00, 4'b1000, 1, 1, 5'd1, 5'd2, 5'd3, 16'h0, 1, 2'd0, 32'h24221800);
    send(0, 0, 1, 0, 2'b00, 4'b1000, 0, 1, 5'd1, 5'd2, 5'd3, 16'h0, 1, 2'd1, 32'h28221800);
    send(0, 0, 0, 1, 2'b01, 4'b0000, 0, 0, 5'd7, 5'd3, 5'd0, 16'h0005, 1, 2'd2, 32'hA0030005);
    pulse_clear();
    // JMP, NOP, BNE, then an unsupported R-type command
    send(0, 0, 0, 1, 2'b11, 4'b0000, 0, 0, 5'd0, 5'd0, 5'd0, 16'h0100, 1, 2'd0, 32'hA8000100);
    send(0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 5'd0, 5'd0, 5'd0, 16'h0000, 1, 2'd1, 32'h00000000);
    send(0, 0, 0, 1, 2'b10, 4'b0000, 0, 1, 5'd0, 5'd1, 5'd2, 16'hFFFF, 1, 2'd2, 32'hA441FFFF);
    send(0, 0, 1, 0, 2'b00, 4'b0001, 0, 1, 5'd1, 5'd1, 5'd1, 16'h0, 0, 2'd0, 32'h0);
    chk("badcmd_err",   {31'b0, err}, 32'd1);
    chk("badcmd_addr",  {30'b0, im_addr}, 32'd3);
    chk("badcmd_count", {29'b0, count}, 32'd3);
    pulse_clear();

    // clear landing on the write cycle drops the write
    drive(0, 0, 1, 0, 2'b00, 4'b0000, 0, 1, 5'd3, 5'd1, 5'd2, 16'h0);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 clear = 1'b1;
    #1 chk("clr_wr_drop", {31'b0, im_wr_en}, 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clrwr_addr",  {30'b0, im_addr}, 32'd0);
    chk("clrwr_count", {29'b0, count}, 32'd0);

    // reset landing on the write cycle
    send(0, 0, 1, 0, 2'b00, 4'b0000, 0, 1, 5'd3, 5'd1, 5'd2, 16'h0, 1, 2'd0, 32'h04611000);
    drive(0, 0, 1, 0, 2'b00, 4'b0010, 0, 1, 5'd6, 5'd1, 5'd2, 16'h0);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rstwr_wr_en", {31'b0, im_wr_en}, 32'd0);
    chk("rstwr_count", {29'b0, count}, 32'd0);
    chk("rstwr_addr",  {30'b0, im_addr}, 32'd0);
    chk("rstwr_wdata", im_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // SUB r6 = r1 - r2 after recovery
    send(0, 0, 1, 0, 2'b00, 4'b0010, 0, 1, 5'd6, 5'd1, 5'd2, 16'h0, 1, 2'd0, 32'h0CC11000);
    chk("post_rst_count", {29'b0, count}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
